hazard_unit_sb: RTL and testbench
=================================

Name: hazard_unit_sb

Overview:
- Parametrised successor to the 5-stage RV32 pipeline hazard/forwarding unit.
- Keeps E/M/W→D and M/W→E forwarding and the load-use and branch-on-load stalls.
- Adds a blocking multi-cycle MDU (mul/div) hold FSM and branch-misprediction flush.
- Adds saturating stall/flush performance counters.
- Sits beside the datapath and drives every stage's stall/flush and forward-select.

Parameters:
- REG_W, 5: register index width.
- LAT_W, 6: MDU latency field width (max latency 2^LAT_W-1).
- PERF_W, 32: perf counter width.
- FWD_D_EN, 1: 0 forces forward_A_D/forward_B_D to 2'b00 (no decode forwarding).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W  in  REG_W  register indices
- we_reg_E, we_reg_M, we_reg_W  in  1  regfile write enables
- wb_ctrl_E, wb_ctrl_M  in  2  writeback select; 2'b01 = load
- branch_D  in  1  D-stage instruction is a branch/jalr
- pred_taken_D  in  1  predictor's taken guess for D
- PC_src_D  in  1  resolved taken in D
- mdu_issue_E  in  1  multi-cycle op in E
- mdu_lat_E  in  LAT_W  nominal latency of that op
- mdu_done  in  1  MDU early completion (e.g. div-by-zero)
- perf_clr  in  1  synchronous perf counter clear
- stall_F, stall_D, stall_E  out  1
- flush_D, flush_E, flush_M  out  1
- forward_A_D, forward_B_D  out  2  00 none, 01 E, 10 M, 11 W
- forward_A_E, forward_B_E  out  2  00 none, 01 M, 10 W
- mdu_busy  out  1  FSM not IDLE
- perf_stall_cnt, perf_flush_cnt  out  PERF_W

Interface fixed: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset (async, rst_n low):
  - FSM←IDLE, cnt←0, perf counters←0.
  - All outputs 0 while rst_n is low.
  - Reset mid-MDU aborts the hold immediately.
- Forwarding (combinational):
  - Priority is nearest stage first.
  - A source matches only if rs≠0, rs==rd_X and we_reg_X.
- ld_stall: wb_ctrl_E==01, we_reg_E, rd_E≠0 and (rs1_D==rd_E or rs2_D==rd_E).
  - Each operand is compared independently; x0 never matches.
- br_stall: branch_D, wb_ctrl_M==01, rd_M≠0 and (rs1_D==rd_M or rs2_D==rd_M).
- MDU FSM states: IDLE, BUSY, RELEASE.
  - IDLE, mdu_issue_E, mdu_lat_E≥2, !mdu_done: mdu_hold=1.
    - cnt←mdu_lat_E-2.
    - Next state is BUSY if cnt≠0, else RELEASE.
  - IDLE, issue with latency 0/1 or mdu_done: no hold; stay IDLE.
  - BUSY: mdu_hold=1.
    - If cnt==1 or mdu_done: next RELEASE.
    - Otherwise cnt←cnt-1.
  - RELEASE: mdu_hold=0; mdu_issue_E ignored (same op still in E); next IDLE.
  - Net effect: an op of latency L occupies E for exactly L cycles with L-1 hold cycles.
- Output priority:
  - mdu_hold: stall_F/D/E=1, flush_M=1, flush_D=0, flush_E=0. D must not resolve while frozen.
  - Else ld_stall or br_stall: stall_F=stall_D=1, flush_E=1, stall_E=0, flush_D=0.
  - Else: flush_D = branch_D & (pred_taken_D ≠ PC_src_D); other outputs 0.
- Perf counters:
  - perf_stall_cnt +1 in each cycle stall_F=1.
  - perf_flush_cnt +1 in each cycle flush_D=1.
  - Both saturate at all-ones.
  - perf_clr has priority over increment.

Decomposition:
- Package hazard_pkg holds:
  - forward-select localparams (FWD_NONE/E/M/W);
  - WB_LOAD=2'b01;
  - MDU FSM state enum typedef.
- Sub-module perf_sat_cnt (PERF_W, inc, clr) is instantiated twice.
- Forwarding and stall detection stay inline.

Test Plan:
- Reset mid-BUSY: issue with L=8, drop rst_n at cycle 3 → mdu_busy=0 and stalls=0 immediately; after release, a new issue holds again for 7 cycles.
- Load-use: rd_E=5, wb_ctrl_E=01, rs2_D=5 → stall_F=stall_D=flush_E=1 for one cycle. With rs1_D=0, rs2_D=0 and rd_E=0 → no stall.
- MDU L=4: mdu_issue_E held high → stall_E=1 for exactly 3 cycles, flush_M=1 for the same 3 cycles, then RELEASE, then IDLE. L=1 → no stall.
- Early done: L=34, mdu_done pulsed in BUSY cycle 5 → hold drops the next cycle after one RELEASE cycle.
- Misprediction: branch_D=1, pred_taken_D=0, PC_src_D=1 → flush_D=1. The same pattern during mdu_hold → flush_D=0. perf_flush_cnt increments only in the first case.
- Forwarding priority: rs1_D=7 with rd_E=rd_M=rd_W=7 and all we=1 → forward_A_D=01. With FWD_D_EN=0 → 00. With rs1_E=7, rd_M=7, rd_W=7 → forward_A_E=01.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the RV32 hazard/forwarding unit: forward selects,
// writeback classes and the MDU hold FSM states.
package hazard_pkg;

  // Decode-stage forward select (nearest producer wins)
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_E    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;
  localparam logic [1:0] FWD_W    = 2'b11;

  // Execute-stage forward select
  localparam logic [1:0] FWD_EX_M = 2'b01;
  localparam logic [1:0] FWD_EX_W = 2'b10;

  localparam logic [1:0] WB_LOAD  = 2'b01;

  typedef enum logic [1:0] {
    MDU_IDLE    = 2'b00,
    MDU_BUSY    = 2'b01,
    MDU_RELEASE = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/perf_sat_cnt.sv
// Saturating event counter with synchronous clear; clear beats increment.
module perf_sat_cnt #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  output logic [PERF_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/hazard_unit_sb.sv
// 5-stage RV32 hazard unit: forwarding, load-use/branch stalls,
// multi-cycle MDU hold, mispredict flush and stall/flush perf counters.
module hazard_unit_sb
  import hazard_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int LAT_W    = 6,
  parameter int PERF_W   = 32,
  parameter bit FWD_D_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  rs1_D,
  input  logic [REG_W-1:0]  rs2_D,
  input  logic [REG_W-1:0]  rs1_E,
  input  logic [REG_W-1:0]  rs2_E,
  input  logic [REG_W-1:0]  rd_E,
  input  logic [REG_W-1:0]  rd_M,
  input  logic [REG_W-1:0]  rd_W,
  input  logic              we_reg_E,
  input  logic              we_reg_M,
  input  logic              we_reg_W,
  input  logic [1:0]        wb_ctrl_E,
  input  logic [1:0]        wb_ctrl_M,
  input  logic              branch_D,
  input  logic              pred_taken_D,
  input  logic              PC_src_D,
  input  logic              mdu_issue_E,
  input  logic [LAT_W-1:0]  mdu_lat_E,
  input  logic              mdu_done,
  input  logic              perf_clr,
  output logic              stall_F,
  output logic              stall_D,
  output logic              stall_E,
  output logic              flush_D,
  output logic              flush_E,
  output logic              flush_M,
  output logic [1:0]        forward_A_D,
  output logic [1:0]        forward_B_D,
  output logic [1:0]        forward_A_E,
  output logic [1:0]        forward_B_E,
  output logic              mdu_busy,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
);

  // ---------------- forwarding ----------------
  logic a_d_e, a_d_m, a_d_w, b_d_e, b_d_m, b_d_w;
  logic a_e_m, a_e_w, b_e_m, b_e_w;

  assign a_d_e = (rs1_D != '0) && (rs1_D == rd_E) && we_reg_E;
  assign a_d_m = (rs1_D != '0) && (rs1_D == rd_M) && we_reg_M;
  assign a_d_w = (rs1_D != '0) && (rs1_D == rd_W) && we_reg_W;
  assign b_d_e = (rs2_D != '0) && (rs2_D == rd_E) && we_reg_E;
  assign b_d_m = (rs2_D != '0) && (rs2_D == rd_M) && we_reg_M;
  assign b_d_w = (rs2_D != '0) && (rs2_D == rd_W) && we_reg_W;
  assign a_e_m = (rs1_E != '0) && (rs1_E == rd_M) && we_reg_M;
  assign a_e_w = (rs1_E != '0) && (rs1_E == rd_W) && we_reg_W;
  assign b_e_m = (rs2_E != '0) && (rs2_E == rd_M) && we_reg_M;
  assign b_e_w = (rs2_E != '0) && (rs2_E == rd_W) && we_reg_W;

  logic [1:0] fa_d, fb_d, fa_e, fb_e;

  always_comb begin
    fa_d = FWD_NONE;
    fb_d = FWD_NONE;
    fa_e = FWD_NONE;
    fb_e = FWD_NONE;
    if (FWD_D_EN) begin
      if      (a_d_e) fa_d = FWD_E;
      else if (a_d_m) fa_d = FWD_M;
      else if (a_d_w) fa_d = FWD_W;
      if      (b_d_e) fb_d = FWD_E;
      else if (b_d_m) fb_d = FWD_M;
      else if (b_d_w) fb_d = FWD_W;
    end
    if      (a_e_m) fa_e = FWD_EX_M;
    else if (a_e_w) fa_e = FWD_EX_W;
    if      (b_e_m) fb_e = FWD_EX_M;
    else if (b_e_w) fb_e = FWD_EX_W;
  end

  // ---------------- stall detection ----------------
  logic ld_stall, br_stall;

  assign ld_stall = (wb_ctrl_E == WB_LOAD) && we_reg_E && (rd_E != '0) &&
                    ((rs1_D == rd_E) || (rs2_D == rd_E));
  assign br_stall = branch_D && (wb_ctrl_M == WB_LOAD) && (rd_M != '0) &&
                    ((rs1_D == rd_M) || (rs2_D == rd_M));

  // ---------------- MDU hold FSM ----------------
  mdu_state_e       state, state_nxt;
  logic [LAT_W-1:0] cnt, cnt_nxt;
  logic             mdu_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MDU_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mdu_hold  = 1'b0;
    case (state)
      MDU_IDLE: begin
        if (mdu_issue_E && (mdu_lat_E >= LAT_W'(2)) && !mdu_done) begin
          mdu_hold  = 1'b1;
          cnt_nxt   = mdu_lat_E - LAT_W'(2);
          state_nxt = (mdu_lat_E != LAT_W'(2)) ? MDU_BUSY : MDU_RELEASE;
        end
      end
      MDU_BUSY: begin
        mdu_hold = 1'b1;
        if (cnt == LAT_W'(1) || mdu_done) state_nxt = MDU_RELEASE;
        else                              cnt_nxt   = cnt - LAT_W'(1);
      end
      // The finished op is still sitting in E, so a held issue is not a new op
      MDU_RELEASE: state_nxt = MDU_IDLE;
      default:     state_nxt = MDU_IDLE;
    endcase
  end

  // ---------------- stall / flush priority ----------------
  logic s_f, s_d, s_e, f_d, f_e, f_m;

  always_comb begin
    s_f = 1'b0;
    s_d = 1'b0;
    s_e = 1'b0;
    f_d = 1'b0;
    f_e = 1'b0;
    f_m = 1'b0;
    if (mdu_hold) begin
      // D is frozen, so a branch there must not resolve yet
      s_f = 1'b1;
      s_d = 1'b1;
      s_e = 1'b1;
      f_m = 1'b1;
    end else if (ld_stall || br_stall) begin
      s_f = 1'b1;
      s_d = 1'b1;
      f_e = 1'b1;
    end else begin
      f_d = branch_D && (pred_taken_D != PC_src_D);
    end
  end

  // Everything reads as zero while reset is held
  assign stall_F     = rst_n & s_f;
  assign stall_D     = rst_n & s_d;
  assign stall_E     = rst_n & s_e;
  assign flush_D     = rst_n & f_d;
  assign flush_E     = rst_n & f_e;
  assign flush_M     = rst_n & f_m;
  assign forward_A_D = rst_n ? fa_d : FWD_NONE;
  assign forward_B_D = rst_n ? fb_d : FWD_NONE;
  assign forward_A_E = rst_n ? fa_e : FWD_NONE;
  assign forward_B_E = rst_n ? fb_e : FWD_NONE;
  assign mdu_busy    = rst_n & (state != MDU_IDLE);

  // ---------------- perf counters ----------------
  perf_sat_cnt #(.PERF_W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_F),
    .clr   (perf_clr),
    .cnt   (perf_stall_cnt)
  );

  perf_sat_cnt #(.PERF_W(PERF_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_D),
    .clr   (perf_clr),
    .cnt   (perf_flush_cnt)
  );

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Directed bench for hazard_unit_sb; a second instance with decode forwarding
// disabled and 2-bit perf counters covers the parameter and saturation cases.
module tb_hazard_unit_sb;

  logic       clk, rst_n;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic       we_reg_E, we_reg_M, we_reg_W;
  logic [1:0] wb_ctrl_E, wb_ctrl_M;
  logic       branch_D, pred_taken_D, PC_src_D;
  logic       mdu_issue_E, mdu_done, perf_clr;
  logic [5:0] mdu_lat_E;

  logic        stall_F, stall_D, stall_E, flush_D, flush_E, flush_M, mdu_busy;
  logic [1:0]  forward_A_D, forward_B_D, forward_A_E, forward_B_E;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  logic        stall_F2, stall_D2, stall_E2, flush_D2, flush_E2, flush_M2, mdu_busy2;
  logic [1:0]  forward_A_D2, forward_B_D2, forward_A_E2, forward_B_E2;
  logic [1:0]  perf_stall_cnt2, perf_flush_cnt2;

  int n_chk  = 0;
  int n_fail = 0;

  hazard_unit_sb dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
    .we_reg_E(we_reg_E), .we_reg_M(we_reg_M), .we_reg_W(we_reg_W),
    .wb_ctrl_E(wb_ctrl_E), .wb_ctrl_M(wb_ctrl_M),
    .branch_D(branch_D), .pred_taken_D(pred_taken_D), .PC_src_D(PC_src_D),
    .mdu_issue_E(mdu_issue_E), .mdu_lat_E(mdu_lat_E), .mdu_done(mdu_done),
    .perf_clr(perf_clr),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
    .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M),
    .forward_A_D(forward_A_D), .forward_B_D(forward_B_D),
    .forward_A_E(forward_A_E), .forward_B_E(forward_B_E),
    .mdu_busy(mdu_busy),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  hazard_unit_sb #(.PERF_W(2), .FWD_D_EN(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
    .we_reg_E(we_reg_E), .we_reg_M(we_reg_M), .we_reg_W(we_reg_W),
    .wb_ctrl_E(wb_ctrl_E), .wb_ctrl_M(wb_ctrl_M),
    .branch_D(branch_D), .pred_taken_D(pred_taken_D), .PC_src_D(PC_src_D),
    .mdu_issue_E(mdu_issue_E), .mdu_lat_E(mdu_lat_E), .mdu_done(mdu_done),
    .perf_clr(perf_clr),
    .stall_F(stall_F2), .stall_D(stall_D2), .stall_E(stall_E2),
    .flush_D(flush_D2), .flush_E(flush_E2), .flush_M(flush_M2),
    .forward_A_D(forward_A_D2), .forward_B_D(forward_B_D2),
    .forward_A_E(forward_A_E2), .forward_B_E(forward_B_E2),
    .mdu_busy(mdu_busy2),
    .perf_stall_cnt(perf_stall_cnt2), .perf_flush_cnt(perf_flush_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    rs1_D = '0; rs2_D = '0; rs1_E = '0; rs2_E = '0;
    rd_E = '0; rd_M = '0; rd_W = '0;
    we_reg_E = 0; we_reg_M = 0; we_reg_W = 0;
    wb_ctrl_E = '0; wb_ctrl_M = '0;
    branch_D = 0; pred_taken_D = 0; PC_src_D = 0;
    mdu_issue_E = 0; mdu_lat_E = '0; mdu_done = 0; perf_clr = 0;
  endtask

  // inputs change 1 time unit after the rising edge
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_in();
    #3;
    chk("rst_stall_F", stall_F, 0);
    chk("rst_busy", mdu_busy, 0);
    chk("rst_perf_stall", perf_stall_cnt, 0);
    chk("rst_perf_flush", perf_flush_cnt, 0);
    // hazard pattern while in reset must stay masked
    rd_E = 5; wb_ctrl_E = 2'b01; we_reg_E = 1; rs2_D = 5; rs1_D = 5; rd_M = 5; we_reg_M = 1;
    #1;
    chk("rst_mask_stall", stall_F, 0);
    chk("rst_mask_flushE", flush_E, 0);
    chk("rst_mask_fwd", forward_A_D, 0);
    nxt();
    rst_n = 1'b1;
    clr_in();

    // load-use on rs2
    nxt(); clr_in();
    rd_E = 5; wb_ctrl_E = 2'b01; we_reg_E = 1; rs2_D = 5; rs1_D = 3;
    #1;
    chk("ld_stall_F", stall_F, 1);
    chk("ld_stall_D", stall_D, 1);
    chk("ld_flush_E", flush_E, 1);
    chk("ld_stall_E", stall_E, 0);
    chk("ld_flush_M", flush_M, 0);

    // x0 never creates a load-use hazard
    nxt(); clr_in();
    wb_ctrl_E = 2'b01; we_reg_E = 1;
    #1;
    chk("ld_x0_stall", stall_F, 0);
    chk("ld_perf_stall", perf_stall_cnt, 1);

    // branch on a load in M, with a mispredict pattern that must not flush D
    nxt(); clr_in();
    branch_D = 1; PC_src_D = 1; wb_ctrl_M = 2'b01; rd_M = 6; we_reg_M = 1; rs1_D = 6;
    #1;
    chk("br_stall_F", stall_F, 1);
    chk("br_flush_E", flush_E, 1);
    chk("br_flush_D", flush_D, 0);
    chk("br_stall_E", stall_E, 0);

    // mispredict
    nxt(); clr_in();
    branch_D = 1; pred_taken_D = 0; PC_src_D = 1;
    #1;
    chk("mis_flush_D", flush_D, 1);
    chk("mis_stall_F", stall_F, 0);
    chk("mis_perf_stall", perf_stall_cnt, 2);
    chk("mis_perf_flush_pre", perf_flush_cnt, 0);

    // correct prediction: no flush
    nxt(); clr_in();
    branch_D = 1; pred_taken_D = 1; PC_src_D = 1;
    #1;
    chk("pred_ok_flush_D", flush_D, 0);
    chk("mis_perf_flush", perf_flush_cnt, 1);

    // forwarding priority
    nxt(); clr_in();
    rs1_D = 7; rd_E = 7; rd_M = 7; rd_W = 7; we_reg_E = 1; we_reg_M = 1; we_reg_W = 1;
    #1;
    chk("fwdAD_E", forward_A_D, 2'b01);
    chk("fwdAD_off", forward_A_D2, 2'b00);
    chk("fwdBD_none", forward_B_D, 2'b00);
    #1 we_reg_E = 0; #1;
    chk("fwdAD_M", forward_A_D, 2'b10);
    #1 we_reg_M = 0; rs2_D = 7; #1;
    chk("fwdAD_W", forward_A_D, 2'b11);
    chk("fwdBD_W", forward_B_D, 2'b11);
    #1 rs1_E = 7; we_reg_M = 1; we_reg_W = 1; #1;
    chk("fwdAE_M", forward_A_E, 2'b01);
    #1 we_reg_M = 0; #1;
    chk("fwdAE_W", forward_A_E, 2'b10);
    #1 rd_W = 0; rs2_E = 0; #1;
    chk("fwdBE_x0", forward_B_E, 2'b00);
    chk("fwd_no_stall", stall_F, 0);

    // MDU latency 4 with issue held; mispredict during hold must not flush
    nxt(); clr_in();
    mdu_issue_E = 1; mdu_lat_E = 4; branch_D = 1; PC_src_D = 1;
    #1;
    chk("l4_h1_stall_E", stall_E, 1);
    chk("l4_h1_flush_M", flush_M, 1);
    chk("l4_h1_stall_F", stall_F, 1);
    chk("l4_h1_flush_D", flush_D, 0);
    chk("l4_h1_flush_E", flush_E, 0);
    chk("l4_h1_busy", mdu_busy, 0);
    for (int i = 2; i <= 3; i++) begin
      nxt(); #1;
      chk("l4_hold_stall_E", stall_E, 1);
      chk("l4_hold_flush_M", flush_M, 1);
      chk("l4_hold_busy", mdu_busy, 1);
    end
    nxt(); branch_D = 0; PC_src_D = 0; #1;
    chk("l4_rel_stall_E", stall_E, 0);
    chk("l4_rel_flush_M", flush_M, 0);
    chk("l4_rel_busy", mdu_busy, 1);
    chk("l4_perf_stall", perf_stall_cnt, 5);
    chk("l4_perf_flush", perf_flush_cnt, 1);
    chk("l4_perf_sat", perf_stall_cnt2, 3);
    nxt(); mdu_issue_E = 0; #1;
    chk("l4_idle_busy", mdu_busy, 0);
    chk("l4_idle_stall_E", stall_E, 0);

    // latency 1: no hold
    nxt(); clr_in();
    mdu_issue_E = 1; mdu_lat_E = 1;
    #1;
    chk("l1_stall_E", stall_E, 0);
    nxt(); mdu_issue_E = 0; #1;
    chk("l1_busy", mdu_busy, 0);

    // latency 34, early done in BUSY cycle 5
    nxt(); clr_in();
    mdu_issue_E = 1; mdu_lat_E = 34;
    #1;
    chk("ed_h_stall_E", stall_E, 1);
    repeat (4) nxt();
    nxt(); mdu_done = 1; #1;
    chk("ed_b5_stall_E", stall_E, 1);
    chk("ed_b5_busy", mdu_busy, 1);
    nxt(); mdu_done = 0; #1;
    chk("ed_rel_stall_E", stall_E, 0);
    chk("ed_rel_busy", mdu_busy, 1);
    nxt(); mdu_issue_E = 0; #1;
    chk("ed_idle_busy", mdu_busy, 0);

    // reset in the middle of a latency-8 hold
    nxt(); clr_in();
    mdu_issue_E = 1; mdu_lat_E = 8;
    nxt(); nxt(); #1;
    chk("rb_c3_busy", mdu_busy, 1);
    chk("rb_c3_stall_F", stall_F, 1);
    rst_n = 1'b0;
    #1;
    chk("rb_busy", mdu_busy, 0);
    chk("rb_stall_F", stall_F, 0);
    chk("rb_stall_E", stall_E, 0);
    chk("rb_flush_M", flush_M, 0);
    chk("rb_perf_stall", perf_stall_cnt, 0);
    nxt();
    rst_n = 1'b1;
    #1;
    chk("rb_new_h1", stall_E, 1);
    for (int i = 2; i <= 7; i++) begin
      nxt(); #1;
      chk("rb_new_hold", stall_E, 1);
    end
    nxt(); #1;
    chk("rb_new_rel_stall_E", stall_E, 0);
    chk("rb_new_rel_busy", mdu_busy, 1);
    chk("rb_perf_stall", perf_stall_cnt, 7);
    chk("rb_perf_sat", perf_stall_cnt2, 3);

    // clear wins over a simultaneous increment
    nxt(); clr_in();
    perf_clr = 1; rd_E = 5; wb_ctrl_E = 2'b01; we_reg_E = 1; rs1_D = 5;
    #1;
    chk("clr_stall_F", stall_F, 1);
    nxt(); clr_in(); #1;
    chk("clr_perf_stall", perf_stall_cnt, 0);
    chk("clr_perf_stall2", perf_stall_cnt2, 0);
    chk("clr_perf_flush", perf_flush_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
